// File: rtl/uart_rx_mnt_param_if.sv
// Read-side bundle of the UART receive monitor: FIFO head, level and error status.
interface uart_rx_mnt_param_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic                 rd_valid;
    logic                 rd_ready;
    logic [DATA_BITS-1:0] rd_data;
    logic                 rd_perr;
    logic                 rd_ferr;
    logic [LW-1:0]        fifo_level;
    logic                 overrun;
    logic                 err_clr;

    modport master (
        output rd_valid, rd_data, rd_perr, rd_ferr,
        output fifo_level, overrun,
        input  rd_ready, err_clr
    );

    modport slave (
        input  rd_valid, rd_data, rd_perr, rd_ferr,
        input  fifo_level, overrun,
        output rd_ready, err_clr
    );
endinterface

// File: rtl/uart_rx_mnt_param.sv
// UART receive monitor: 16x oversampling, 3-sample majority vote,
// parity/stop checking and a FIFO of {perr, ferr, data} entries.
module uart_rx_mnt_param #(
    parameter int OSR_DIV    = 325,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic clk,
    input  logic rst_b,
    input  logic rx_en,
    input  logic rxd,
    uart_rx_mnt_param_if.master rd
);
    localparam int CW = (OSR_DIV > 1) ? $clog2(OSR_DIV) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    typedef struct packed {
        logic                 perr;
        logic                 ferr;
        logic [DATA_BITS-1:0] data;
    } ent_t;

    logic [CW-1:0] tcnt;
    logic          tick;
    logic          s1, s2, prv;

    assign tick = (tcnt == '0);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            tcnt <= CW'(OSR_DIV - 1);
        end else if (tick) begin
            tcnt <= CW'(OSR_DIV - 1);
        end else begin
            tcnt <= tcnt - 1'b1;
        end
    end

    // prv holds the previous tick's sample for falling-edge detection
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            s1  <= 1'b1;
            s2  <= 1'b1;
            prv <= 1'b1;
        end else begin
            s1 <= rxd;
            s2 <= s1;
            if (tick) prv <= s2;
        end
    end

    state_t               state, state_n;
    logic [3:0]           si, si_n;
    logic [3:0]           bcnt, bcnt_n;
    logic [1:0]           scnt, scnt_n;
    logic [DATA_BITS-1:0] sh, sh_n;
    logic                 perr, perr_n;
    logic                 ferr, ferr_n;
    logic                 v7, v7_n, v8, v8_n;
    logic                 maj;
    logic                 push;
    ent_t                 w_ent;

    assign maj = (v7 & v8) | (s2 & (v7 | v8));

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
            si    <= '0;
            bcnt  <= '0;
            scnt  <= '0;
            sh    <= '0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
            v7    <= 1'b1;
            v8    <= 1'b1;
        end else begin
            state <= state_n;
            si    <= si_n;
            bcnt  <= bcnt_n;
            scnt  <= scnt_n;
            sh    <= sh_n;
            perr  <= perr_n;
            ferr  <= ferr_n;
            v7    <= v7_n;
            v8    <= v8_n;
        end
    end

    always_comb begin
        state_n = state;
        si_n    = si;
        bcnt_n  = bcnt;
        scnt_n  = scnt;
        sh_n    = sh;
        perr_n  = perr;
        ferr_n  = ferr;
        v7_n    = v7;
        v8_n    = v8;
        push    = 1'b0;
        w_ent   = '{perr: perr, ferr: ferr | ~maj, data: sh};
        if (!rx_en) begin
            state_n = IDLE;
        end else if (tick) begin
            si_n = si + 4'd1;
            if (si == 4'd7) v7_n = s2;
            if (si == 4'd8) v8_n = s2;
            unique case (state)
                IDLE: begin
                    si_n = '0;
                    if (prv && !s2) begin
                        state_n = START;
                        bcnt_n  = '0;
                        scnt_n  = '0;
                        perr_n  = 1'b0;
                        ferr_n  = 1'b0;
                    end
                end
                START: begin
                    if (si == 4'd9 && maj) begin
                        state_n = IDLE;
                    end else if (si == 4'd15) begin
                        state_n = DATA;
                    end
                end
                DATA: begin
                    if (si == 4'd9) sh_n = {maj, sh[DATA_BITS-1:1]};
                    if (si == 4'd15) begin
                        if (bcnt == 4'(DATA_BITS - 1)) begin
                            state_n = (PARITY != 0) ? PAR : STOP;
                        end else begin
                            bcnt_n = bcnt + 4'd1;
                        end
                    end
                end
                PAR: begin
                    if (si == 4'd9) begin
                        perr_n = (PARITY == 1) ? ~(^sh ^ maj) : (^sh ^ maj);
                    end
                    if (si == 4'd15) state_n = STOP;
                end
                STOP: begin
                    if (si == 4'd9) begin
                        if (!maj) ferr_n = 1'b1;
                        if (scnt == 2'(STOP_BITS - 1)) begin
                            push    = 1'b1;
                            state_n = IDLE;
                        end
                    end
                    if (si == 4'd15) scnt_n = scnt + 2'd1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    ent_t          mem [FIFO_DEPTH];
    ent_t          head;
    logic [AW:0]   wp, rp, level;
    logic          full, valid, pop, wr;

    assign level = wp - rp;
    assign full  = (level == (AW+1)'(FIFO_DEPTH));
    assign valid = (level != '0);
    assign pop   = valid & rd.rd_ready;
    assign wr    = push & (~full | pop);
    assign head  = mem[rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr) mem[wp[AW-1:0]] <= w_ent;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wp          <= '0;
            rp          <= '0;
            rd.overrun  <= 1'b0;
        end else begin
            if (wr)  wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            if (push && full && !pop) begin
                rd.overrun <= 1'b1;
            end else if (rd.err_clr) begin
                rd.overrun <= 1'b0;
            end
        end
    end

    // Gate the head so the read port reads 0 while storage is unwritten
    assign rd.rd_valid   = valid;
    assign rd.rd_data    = valid ? head.data : '0;
    assign rd.rd_perr    = valid & head.perr;
    assign rd.rd_ferr    = valid & head.ferr;
    assign rd.fifo_level = level;
endmodule
